// File: rtl/ram_bist_controller.sv
// Single-port RAM BIST engine: writes pat(a) = a ^ seed to every address, reads it back and compares.
// Define RAM_BIST_INVERT_PASS_EN to add a second write/read pass using the inverted pattern.
module ram_bist_controller #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  ram_we,
    output logic                  ram_re,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH:0]   err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WRITE     = 3'd1;
    localparam logic [2:0] READ      = 3'd2;
    localparam logic [2:0] DRAIN     = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;
`ifdef RAM_BIST_INVERT_PASS_EN
    localparam logic [2:0] WRITE_INV = 3'd5;
    localparam logic [2:0] READ_INV  = 3'd6;
`endif

    logic [2:0]            state, state_n;
    logic [ADDR_WIDTH-1:0] cnt, cnt_n;
    logic [DATA_WIDTH-1:0] seed_q, seed_n;
    logic                  accept;
    logic                  wr_n, rd_n, inv_wr_n, rd_cur, inv_rd_cur;
    logic                  cmp_valid;
    logic [DATA_WIDTH-1:0] cmp_exp;
    logic [ADDR_WIDTH-1:0] cmp_addr;

    function automatic logic [DATA_WIDTH-1:0] pat(input logic [ADDR_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] s);
        logic [DATA_WIDTH-1:0] ext;
        ext = DATA_WIDTH'(a);
        return ext ^ s;
    endfunction

    assign accept = (state == IDLE) && start;
    assign seed_n = accept ? seed : seed_q;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = WRITE;
                    cnt_n   = '0;
                end
            end
            WRITE: begin
                cnt_n = cnt + 1'b1;
                if (&cnt) state_n = READ;
            end
            READ: begin
                cnt_n = cnt + 1'b1;
`ifdef RAM_BIST_INVERT_PASS_EN
                if (&cnt) state_n = WRITE_INV;
`else
                if (&cnt) state_n = DRAIN;
`endif
            end
`ifdef RAM_BIST_INVERT_PASS_EN
            WRITE_INV: begin
                cnt_n = cnt + 1'b1;
                if (&cnt) state_n = READ_INV;
            end
            READ_INV: begin
                cnt_n = cnt + 1'b1;
                if (&cnt) state_n = DRAIN;
            end
`endif
            DRAIN:   state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next-state view so the bus matches the state each cycle.
`ifdef RAM_BIST_INVERT_PASS_EN
    assign wr_n       = (state_n == WRITE) || (state_n == WRITE_INV);
    assign rd_n       = (state_n == READ) || (state_n == READ_INV);
    assign inv_wr_n   = (state_n == WRITE_INV);
    assign rd_cur     = (state == READ) || (state == READ_INV);
    assign inv_rd_cur = (state == READ_INV);
`else
    assign wr_n       = (state_n == WRITE);
    assign rd_n       = (state_n == READ);
    assign inv_wr_n   = 1'b0;
    assign rd_cur     = (state == READ);
    assign inv_rd_cur = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            seed_q    <= '0;
            ram_we    <= 1'b0;
            ram_re    <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
            cmp_valid <= 1'b0;
            cmp_exp   <= '0;
            cmp_addr  <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            seed_q   <= seed_n;
            ram_we   <= wr_n;
            ram_re   <= rd_n;
            ram_addr <= (wr_n || rd_n) ? cnt_n : '0;
            ram_din  <= wr_n ? (pat(cnt_n, seed_n) ^ {DATA_WIDTH{inv_wr_n}}) : '0;
            busy     <= (state_n != IDLE) && (state_n != DONE);
            done     <= (state_n == DONE);
            // Read data returns one cycle after issue; carry the expectation alongside it.
            cmp_valid <= rd_cur;
            cmp_exp   <= pat(cnt, seed_q) ^ {DATA_WIDTH{inv_rd_cur}};
            cmp_addr  <= cnt;
            if (accept) begin
                fail      <= 1'b0;
                err_count <= '0;
                fail_addr <= '0;
            end else if (cmp_valid && (ram_dout != cmp_exp)) begin
                fail <= 1'b1;
                if (!(&err_count)) err_count <= err_count + 1'b1;
                if (!fail) fail_addr <= cmp_addr;
            end
        end
    end

endmodule

// File: tb/tb_ram_bist_controller.sv
// Directed bench for ram_bist_controller: RAM model with injectable faults, access scoreboard, result model.
// Follows RAM_BIST_INVERT_PASS_EN when the bundle is built with it.
module tb_ram_bist_controller;

    localparam int W = 9;
`ifdef RAM_BIST_INVERT_PASS_EN
    localparam int DONE_CYC = 66;
`else
    localparam int DONE_CYC = 34;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] seed = 4'h0;
    logic       ram_we, ram_re;
    logic [3:0] ram_addr, ram_din;
    logic [3:0] ram_dout = 4'h0;
    logic       busy, done, fail;
    logic [4:0] err_count;
    logic [3:0] fail_addr;

    ram_bist_controller #(.DATA_WIDTH(4), .ADDR_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .seed(seed),
        .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .busy(busy), .done(done), .fail(fail),
        .err_count(err_count), .fail_addr(fail_addr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int e0 = 0;
    int exp_err = 0;
    int exp_fa = 0;
    logic [W-1:0] exp_q[$];

    // Fault configuration applied on the RAM read path
    logic       stuck_en = 1'b0;
    logic [3:0] stuck_addr = 4'h0;
    int         stuck_bit = 0;
    logic       stuck_val = 1'b0;
    logic       corrupt_all = 1'b0;
    logic [3:0] mem [16];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] fault(input logic [3:0] a, input logic [3:0] v);
        logic [3:0] r;
        r = v;
        if (stuck_en && a == stuck_addr) r[stuck_bit] = stuck_val;
        if (corrupt_all) r = r ^ 4'h1;
        return r;
    endfunction

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        if (ram_re) ram_dout <= fault(ram_addr, mem[ram_addr]);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: every access must match the next scoreboard entry; idle bus must be all zero.
    always @(negedge clk) begin
        if (!reset) begin
            check("we_re_exclusive", {31'd0, ram_we & ram_re}, 32'd0);
            if (ram_we || ram_re) begin
                check("busy_during_access", {31'd0, busy}, 32'd1);
                check("access", {22'd0, 1'b1, ram_we, ram_addr, (ram_we ? ram_din : 4'h0)},
                      (exp_q.size() > 0) ? {22'd0, 1'b1, exp_q.pop_front()} : 32'd0);
            end else begin
                check("idle_bus", {24'd0, ram_addr, ram_din}, 32'd0);
            end
        end
    end

    function automatic void model(input logic [3:0] s, output int e, output int fa);
        logic [3:0] p;
        bit found;
        e = 0; fa = 0; found = 0;
        for (int a = 0; a < 16; a++) begin
            p = 4'(a) ^ s;
            if (fault(4'(a), p) != p) begin
                e++;
                if (!found) begin fa = a; found = 1; end
            end
        end
`ifdef RAM_BIST_INVERT_PASS_EN
        for (int a = 0; a < 16; a++) begin
            p = ~(4'(a) ^ s);
            if (fault(4'(a), p) != p) begin
                e++;
                if (!found) begin fa = a; found = 1; end
            end
        end
`endif
        if (e > 31) e = 31;
    endfunction

    task automatic start_run(input logic [3:0] s);
        model(s, exp_err, exp_fa);
        for (int a = 0; a < 16; a++) exp_q.push_back({1'b1, 4'(a), 4'(a) ^ s});
        for (int a = 0; a < 16; a++) exp_q.push_back({1'b0, 4'(a), 4'h0});
`ifdef RAM_BIST_INVERT_PASS_EN
        for (int a = 0; a < 16; a++) exp_q.push_back({1'b1, 4'(a), ~(4'(a) ^ s)});
        for (int a = 0; a < 16; a++) exp_q.push_back({1'b0, 4'(a), 4'h0});
`endif
        @(negedge clk);
        start = 1'b1;
        seed  = s;
        @(posedge clk);
        #1;
        e0 = cyc;
        start = 1'b0;
        seed  = $urandom_range(0, 15);
    endtask

    task automatic finish_run(input string tag);
        bit seen;
        int rel;
        seen = 0;
        rel = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                rel = cyc - e0 + 1;
                break;
            end
        end
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            check({tag, "_done_cycle"}, rel, DONE_CYC);
            check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
            check({tag, "_fail"}, {31'd0, fail}, (exp_err != 0) ? 32'd1 : 32'd0);
            check({tag, "_err_count"}, {27'd0, err_count}, exp_err);
            check({tag, "_fail_addr"}, {28'd0, fail_addr}, exp_fa);
            check({tag, "_queue_empty"}, exp_q.size(), 32'd0);
            @(negedge clk);
            check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
            check({tag, "_err_stable"}, {27'd0, err_count}, exp_err);
        end
        exp_q.delete();
    endtask

    initial begin
        bit seen_done;
        repeat (3) @(negedge clk);
        check("reset_values", {19'd0, ram_we, ram_re, ram_addr, ram_din, busy, done, fail,
              err_count, fail_addr}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        start_run(4'h0);
        finish_run("seed0_good");

        start_run(4'hA);
        finish_run("seedA_good");

        stuck_en = 1'b1; stuck_addr = 4'd5; stuck_bit = 1; stuck_val = 1'b1;
        start_run(4'h0);
        finish_run("stuck_b1_hi_a5");

        stuck_bit = 0; stuck_val = 1'b0;
        start_run(4'h0);
        finish_run("stuck_b0_lo_a5");
        stuck_en = 1'b0;

        corrupt_all = 1'b1;
        start_run(4'h3);
        finish_run("corrupt_all_1");
        start_run(4'h3);
        finish_run("corrupt_all_2");
        corrupt_all = 1'b0;

        // A second start mid-test must not disturb the run in progress
        start_run(4'h6);
        repeat (9) @(negedge clk);
        start = 1'b1;
        seed  = 4'hF;
        @(negedge clk);
        start = 1'b0;
        finish_run("start_ignored");

        stuck_en = 1'b1; stuck_addr = 4'd1; stuck_bit = 1; stuck_val = 1'b1;
        start_run(4'h0);
        repeat (20) @(negedge clk);
        check("pre_reset_fail", {31'd0, fail}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_outputs", {19'd0, ram_we, ram_re, ram_addr, ram_din, busy, done, fail,
              err_count, fail_addr}, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        stuck_en = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        check("no_done_after_reset", {31'd0, seen_done}, 32'd0);

        start_run(4'h0);
        finish_run("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
